// File: rtl/obi_rr_arbiter_n_to_one.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : obi_rr_arbiter_n_to_one
// Description : N-master to 1-slave OBI arbiter, round-robin or fixed priority,
//               with request lock and in-order response routing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Request word  {req, we, be[3:0], addr[31:0], wdata[31:0]} = 70 bits.
// Response word {gnt, rvalid, rdata[31:0]}                   = 34 bits.
module obi_rr_arbiter_n_to_one #(
  parameter int NMASTER         = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIXED_PRIO      = 0,
  localparam int IDX_W          = (NMASTER > 1) ? $clog2(NMASTER) : 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
  localparam int REQ_W          = 70,
  localparam int RSP_W          = 34
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NMASTER-1:0][REQ_W-1:0]   master_req_i,
  output logic [NMASTER-1:0][RSP_W-1:0]   master_resp_o,
  input  logic [NMASTER-1:0]              master_en_i,
  output logic [REQ_W-1:0]                slave_req_o,
  input  logic [RSP_W-1:0]                slave_resp_i,
  output logic [CNT_W-1:0]                outstanding_o,
  output logic                            protocol_err_o
);

  localparam int                PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0]  C_MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  C_LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NMASTER - 1);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [NMASTER-1:0] w_eligible;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_winner;
  logic               w_req;
  logic               w_hs;
  logic               w_pop;
  logic [IDX_W-1:0]   w_head;
  logic               w_gnt_in;
  logic               w_rvalid_in;
  logic [31:0]        w_rdata_in;

  assign w_gnt_in    = slave_resp_i[RSP_W-1];
  assign w_rvalid_in = slave_resp_i[RSP_W-2];
  assign w_rdata_in  = slave_resp_i[31:0];

  generate
    for (genvar gi = 0; gi < NMASTER; gi++) begin : g_elig
      assign w_eligible[gi] = master_req_i[gi][REQ_W-1] & master_en_i[gi];
    end
  endgenerate

  // Scan from the far end towards the start so the last hit is the nearest one.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = NMASTER - 1; k >= 0; k--) begin
      if (FIXED_PRIO != 0) begin
        idx = k;
      end else begin
        idx = (int'(r_rr_ptr) + k) % NMASTER;
      end
      if (w_eligible[IDX_W'(idx)]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  assign w_winner = r_lock ? r_lock_idx : w_pick;

  // Occupancy is the registered count, so a same-cycle pop cannot unblock a full FIFO.
  assign w_req  = rst_ni & (r_lock | w_found) & (r_count < C_MAX_CNT);
  assign w_hs   = w_req & w_gnt_in;
  assign w_pop  = rst_ni & w_rvalid_in & (r_count != '0);
  assign w_head = r_fifo[r_rd_ptr];

  assign slave_req_o = w_req ? {1'b1, master_req_i[w_winner][REQ_W-2:0]} : '0;

  generate
    for (genvar gi = 0; gi < NMASTER; gi++) begin : g_resp
      logic w_gnt_m;
      logic w_rv_m;
      assign w_gnt_m = w_hs  & (w_winner == IDX_W'(gi));
      assign w_rv_m  = w_pop & (w_head   == IDX_W'(gi));
      assign master_resp_o[gi] = {w_gnt_m, w_rv_m, (w_rv_m ? w_rdata_in : 32'h0)};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_fifo[r_wr_ptr] <= w_winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lock   <= 1'b0;
        r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
        if (FIXED_PRIO == 0) begin
          r_rr_ptr <= (w_winner == C_LAST_IDX) ? '0 : w_winner + IDX_W'(1);
        end
      end else if (w_req) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_winner;
      end

      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end

      // A response with nothing outstanding is dropped and flagged until reset.
      if (w_rvalid_in && (r_count == '0)) begin
        r_err <= 1'b1;
      end

      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign outstanding_o  = r_count;
  assign protocol_err_o = r_err;

endmodule
`default_nettype wire
